// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 op encodings, FSM states and per-op signedness helpers.
package ex_muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic rs1_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // MULHSU treats rs2 as unsigned, so only MULH/DIV/REM sign-extend rs2.
  function automatic logic rs2_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_dp.sv
// Datapath for ex_muldiv_seq: operand magnitudes, 64-bit accumulator,
// shared 33-bit add/subtract, sign fix-up and result selection.
module ex_muldiv_dp
  import ex_muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  md_op_e          op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            fast,
  output logic [XLEN-1:0] result_fixed,
  output logic [XLEN-1:0] result_held
);

  md_op_e              op_q;
  logic [XLEN-1:0]     a_q;          // multiplicand or divisor magnitude
  logic [XLEN-1:0]     b_q;          // multiplier or dividend magnitude, shifted each step
  logic [2*XLEN-1:0]   acc;
  logic                neg_res_q;
  logic                neg_rem_q;

  logic                neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       add_x, add_y;
  logic [XLEN+1:0]     add_sum;
  logic                borrow;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;

  assign neg1     = rs1_signed(op) & operand1[XLEN-1];
  assign neg2     = rs2_signed(op) & operand2[XLEN-1];
  assign mag1     = neg1 ? -operand1 : operand1;
  assign mag2     = neg2 ? -operand2 : operand2;
  assign div_zero = is_div(op) && (operand2 == '0);
  assign div_ovf  = (op inside {MD_DIV, MD_REM}) &&
                    (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
  assign fast     = div_zero | div_ovf;

  // Divide feeds the next dividend bit into the partial remainder; multiply adds
  // the multiplicand when the current multiplier LSB is set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    add_x   = {1'b0, acc[2*XLEN-1:XLEN]};
    add_y   = {1'b0, a_q};
    add_sum = '0;
    if (is_div(op_q)) begin
      add_x   = {acc[2*XLEN-1:XLEN], b_q[XLEN-1]};
      add_sum = {1'b0, add_x} - {1'b0, add_y};
    end else begin
      add_sum = {1'b0, add_x} + (b_q[0] ? {1'b0, add_y} : '0);
    end
  end
  assign borrow = add_sum[XLEN+1];

  always_comb begin
    prod         = neg_res_q ? -acc : acc;
    quo          = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem          = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result_fixed = prod[XLEN-1:0];
    case (op_q)
      MD_MUL:                       result_fixed = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_fixed = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_fixed = quo;
      default:                      result_fixed = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      op_q        <= MD_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_held <= '0;
    end else begin
      if (load) begin
        op_q      <= op;
        a_q       <= is_div(op) ? mag2 : mag1;
        b_q       <= is_div(op) ? mag1 : mag2;
        neg_res_q <= neg1 ^ neg2;
        neg_rem_q <= neg1;
        acc       <= '0;
        // Fast paths preload {remainder, quotient} with sign fix-up disabled.
        if (div_zero) begin
          acc       <= {operand1, 32'hFFFF_FFFF};
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (div_ovf) begin
          acc       <= {32'h0, 32'h8000_0000};
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end
      end else if (step) begin
        if (is_div(op_q)) begin
          acc <= {(borrow ? add_x[XLEN-1:0] : add_sum[XLEN-1:0]), acc[XLEN-2:0], ~borrow};
          b_q <= b_q << 1;
        end else begin
          acc <= {add_sum[XLEN:0], acc[XLEN-1:1]};
          b_q <= b_q >> 1;
        end
      end
      if (finish) result_held <= result_fixed;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX-stage ALU: stalls the front
// end for 32 iterations, then presents the result for exactly one cycle.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               load, step, fast;
  md_op_e             op;
  logic [XLEN-1:0]    result_fixed, result_held;

  assign op = md_op_e'(op_i);

  ex_muldiv_dp u_dp (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .step         (step),
    .finish       (done_o),
    .op           (op),
    .operand1     (operand1_i),
    .operand2     (operand2_i),
    .fast         (fast),
    .result_fixed (result_fixed),
    .result_held  (result_held)
  );

  // kill_i wins in every state: no stall, no done, back to IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          load       = 1'b1;
          stall_o    = 1'b1;
          state_next = fast ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (kill_i) begin
          state_next = S_IDLE;
        end else begin
          step    = 1'b1;
          stall_o = 1'b1;
          if (cnt == '0) state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o     = !kill_i;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load)      cnt <= CNT_W'(XLEN - 1);
      else if (step) cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy_o   = (state != S_IDLE);
  // The finished value is visible in the DONE cycle itself and held afterwards.
  assign result_o = done_o ? result_fixed : result_held;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: scoreboard of expected results, cycle-exact
// stall/done checks, fast paths, kill, reset and start-in-DONE behaviour.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] operand1_i;
  logic [31:0] operand2_i;
  logic        kill_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .kill_i     (kill_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at cycle T and check every cycle up to the expected done cycle.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit fast, input bit start_in_done);
    int lat;
    lat        = fast ? 1 : 33;
    start_i    = 1'b1;
    op_i       = op;
    operand1_i = a;
    operand2_i = b;
    exp_q.push_back(exp);
    #1;
    check($sformatf("%s_stall_T", op.name()), {31'b0, stall_o}, 32'd1);
    check($sformatf("%s_done_T", op.name()), {31'b0, done_o}, 32'd0);
    tick();
    start_i    = 1'b0;
    operand1_i = $urandom;
    operand2_i = $urandom;
    op_i       = 3'($urandom_range(0, 7));
    for (int n = 1; n <= lat; n++) begin
      if (n == lat && start_in_done) start_i = 1'b1;
      #1;
      check($sformatf("%s_stall_T+%0d", op.name(), n), {31'b0, stall_o}, {31'b0, n < lat});
      check($sformatf("%s_busy_T+%0d", op.name(), n), {31'b0, busy_o}, 32'd1);
      check($sformatf("%s_done_T+%0d", op.name(), n), {31'b0, done_o}, {31'b0, n == lat});
      if (done_o === 1'b1 && exp_q.size() > 0)
        check($sformatf("%s_result", op.name()), result_o, exp_q.pop_front());
      tick();
    end
    start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] wide;
    reset_n    = 1'b0;
    start_i    = 1'b0;
    kill_i     = 1'b0;
    op_i       = 3'd0;
    operand1_i = '0;
    operand2_i = '0;
    tick();
    tick();
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op(MD_MUL,    32'd7,          32'd6,          32'd42,         1'b0, 1'b0);
    check("mul_held", result_o, 32'd42);
    run_op(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 1'b0);
    run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 1'b0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op(MD_DIVU,   32'd100,        32'd7,          32'd14,         1'b0, 1'b0);
    run_op(MD_REMU,   32'd100,        32'd7,          32'd2,          1'b0, 1'b0);
    run_op(MD_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0);
    run_op(MD_REMU,   32'd5,          32'd0,          32'd5,          1'b1, 1'b0);
    run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b0);
    run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra   = $urandom;
      rb   = $urandom | 32'd1;
      wide = {32'h0, ra} * {32'h0, rb};
      run_op(MD_MUL,   ra, rb, wide[31:0],  1'b0, 1'b0);
      run_op(MD_MULHU, ra, rb, wide[63:32], 1'b0, 1'b0);
      run_op(MD_DIVU,  ra, rb >> (i * 8), ra / (rb >> (i * 8)), 1'b0, 1'b0);
      run_op(MD_REMU,  ra, rb >> (i * 8), ra % (rb >> (i * 8)), 1'b0, 1'b0);
    end

    // Kill at BUSY iteration 10: no stall that cycle, IDLE next, no result.
    start_i    = 1'b1;
    op_i       = MD_MUL;
    operand1_i = 32'd3;
    operand2_i = 32'd5;
    tick();
    start_i = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    kill_i = 1'b1;
    #1;
    check("kill_stall", {31'b0, stall_o}, 32'd0);
    check("kill_done", {31'b0, done_o}, 32'd0);
    tick();
    kill_i = 1'b0;
    #1;
    check("kill_idle_busy", {31'b0, busy_o}, 32'd0);
    check("kill_idle_done", {31'b0, done_o}, 32'd0);
    check("kill_result_kept", result_o, 32'd1 * 0 + exp_last());
    run_op(MD_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

    // start_i during DONE must not launch a second op.
    run_op(MD_MUL, 32'd11, 32'd13, 32'd143, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      #1;
      check("done_start_busy", {31'b0, busy_o}, 32'd0);
      check("done_start_done", {31'b0, done_o}, 32'd0);
      tick();
    end

    // Synchronous reset mid-BUSY returns every output to its reset value.
    start_i    = 1'b1;
    op_i       = MD_DIV;
    operand1_i = 32'd100;
    operand2_i = 32'd7;
    tick();
    start_i = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    reset_n = 1'b0;
    tick();
    #1;
    check("midrst_stall", {31'b0, stall_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check("midrst_done", {31'b0, done_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    reset_n = 1'b1;
    tick();
    run_op(MD_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Last value the scoreboard expected to complete before the kill test.
  logic [31:0] last_expected;
  function automatic logic [31:0] exp_last();
    return last_expected;
  endfunction

  always @(posedge clk) begin
    if (done_o === 1'b1) last_expected = result_o;
  end

endmodule
